// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin front end that shares one floating-point adder
// among NREQ requesters. Each grant latches one lane's operands, holds the
// adder start level until a fresh result (or a timeout) and then spends one
// RELEASE cycle with the start level low before the next grant.
module fp_add_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 63,
  parameter int QUIET   = 8,
  parameter int DATA_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DATA_W-1:0] op_a,
  input  logic [NREQ*DATA_W-1:0] op_b,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic [DATA_W-1:0]      sum,
  output logic                   err,
  output logic                   busy,
  output logic                   fp_add,
  output logic [DATA_W-1:0]      fp_a,
  output logic [DATA_W-1:0]      fp_b,
  input  logic [DATA_W-1:0]      fp_result,
  input  logic                   fp_ready
);

  localparam int LW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_MAX = (TIMEOUT > QUIET) ? TIMEOUT : QUIET;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [DATA_W-1:0] QNAN      = DATA_W'(32'h7FC00000);
  localparam logic [CNT_W-1:0]  QUIET_END = CNT_W'(QUIET);
  localparam logic [CNT_W-1:0]  TMO_END   = CNT_W'(TIMEOUT - 1);
  // A ready level seen in the first two issue cycles may be left over from
  // the previous operation, so it is not trusted until the counter gets here.
  localparam logic [CNT_W-1:0]  STALE_END = CNT_W'(2);
  localparam logic [LW-1:0]     LANE_LAST = LW'(NREQ - 1);

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    IDLE    = 2'd1,
    ISSUE   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [CNT_W-1:0]  cnt;
  logic [LW-1:0]     last;
  logic [LW-1:0]     win;
  logic [LW-1:0]     pick;
  logic              err_flag;
  logic              grant_go;
  logic              accept;
  logic              tmo;

  // Round-robin search starting one lane after the last served lane.
  function automatic logic [LW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [LW-1:0]   lst);
    logic [LW-1:0] idx;
    logic          found;
    rr_pick = lst;
    found   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = LW'((int'(lst) + k) % NREQ);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // One-hot lane marker for the gnt and done pulses.
  function automatic logic [NREQ-1:0] lane_mask(input logic [LW-1:0] i);
    lane_mask    = '0;
    lane_mask[i] = 1'b1;
  endfunction

  // State register; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
    end else begin
      state <= state_n;
    end
  end

  // Next-state decode plus the one-cycle gnt/done/err pulses.
  always_comb begin
    state_n  = state;
    gnt      = '0;
    done     = '0;
    err      = 1'b0;
    grant_go = 1'b0;
    accept   = 1'b0;
    tmo      = 1'b0;
    pick     = rr_pick(req, last);
    case (state)
      INIT: begin
        if (cnt == QUIET_END) begin
          state_n = IDLE;
        end
      end
      IDLE: begin
        if (|req) begin
          grant_go = 1'b1;
          gnt      = lane_mask(pick);
          state_n  = ISSUE;
        end
      end
      ISSUE: begin
        if ((cnt >= STALE_END) && fp_ready) begin
          accept  = 1'b1;
          state_n = RELEASE;
        end else if (cnt == TMO_END) begin
          tmo     = 1'b1;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        done    = lane_mask(win);
        err     = err_flag;
        state_n = IDLE;
      end
      default: begin
        state_n = INIT;
      end
    endcase
  end

  assign busy = (state != IDLE);

  // Counter, operand latches, result capture and round-robin bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      fp_a     <= '0;
      fp_b     <= '0;
      fp_add   <= 1'b0;
      sum      <= '0;
      err_flag <= 1'b0;
      win      <= LANE_LAST;
      last     <= LANE_LAST;
    end else begin
      case (state)
        INIT: begin
          if (cnt == QUIET_END) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE: begin
          if (grant_go) begin
            fp_a     <= op_a[pick*DATA_W +: DATA_W];
            fp_b     <= op_b[pick*DATA_W +: DATA_W];
            fp_add   <= 1'b1;
            cnt      <= '0;
            win      <= pick;
            err_flag <= 1'b0;
          end
        end
        ISSUE: begin
          if (accept) begin
            sum    <= fp_result;
            fp_add <= 1'b0;
          end else if (tmo) begin
            sum      <= QNAN;
            fp_add   <= 1'b0;
            err_flag <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          last     <= win;
          err_flag <= 1'b0;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule
